// File: rtl/regfile_sched_pkg.sv
// regfile_sched_pkg
// Shared types and helpers for the register-file write-back scheduler.
//   schedState_t : scheduler FSM states (IDLE, DRAIN)
//   NUM_WR_PORTS : register-file write ports drained per cycle
//   MAX_SLOTS    : widest slot mask the helpers accept
//   popcount     : number of set bits in a slot mask
//   lowestSetBit : index of the lowest set bit (0 when the mask is empty)
package regfile_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } schedState_t;

  localparam int NUM_WR_PORTS = 2;
  localparam int MAX_SLOTS    = 8;

  function automatic logic [3:0] popcount(input logic [MAX_SLOTS-1:0] m);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      cnt = cnt + {3'b000, m[i]};
    end
    return cnt;
  endfunction

  function automatic logic [2:0] lowestSetBit(input logic [MAX_SLOTS-1:0] m);
    logic [2:0] idx;
    idx = '0;
    // Scan downwards so the last hit is the lowest index.
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (m[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/lowest_two_picker.sv
// lowest_two_picker
// Purely combinational: picks the two lowest set bits of a slot mask.
//   mask   in  NUM_SLOTS  pending-slot mask
//   grant0 out NUM_SLOTS  one-hot lowest set bit (0 if mask empty)
//   grant1 out NUM_SLOTS  one-hot next-lowest set bit (0 if fewer than two)
//   valid0 out 1          grant0 is meaningful
//   valid1 out 1          grant1 is meaningful
module lowest_two_picker
  import regfile_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0] mask,
  output logic [NUM_SLOTS-1:0] grant0,
  output logic [NUM_SLOTS-1:0] grant1,
  output logic                 valid0,
  output logic                 valid1
);

  logic [MAX_SLOTS-1:0] maskExt;
  logic [MAX_SLOTS-1:0] restExt;
  logic [MAX_SLOTS-1:0] grant0Ext;
  logic [MAX_SLOTS-1:0] grant1Ext;

  always_comb begin
    maskExt                = '0;
    maskExt[NUM_SLOTS-1:0] = mask;
    valid0    = |maskExt;
    grant0Ext = valid0 ? (MAX_SLOTS'(1) << lowestSetBit(maskExt)) : '0;
    // Remove the first winner, then pick again for the second port.
    restExt   = maskExt & ~grant0Ext;
    valid1    = |restExt;
    grant1Ext = valid1 ? (MAX_SLOTS'(1) << lowestSetBit(restExt)) : '0;
  end

  assign grant0 = grant0Ext[NUM_SLOTS-1:0];
  assign grant1 = grant1Ext[NUM_SLOTS-1:0];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
// Captures one VLIW bundle of slot results, drops WAW-shadowed slots (highest
// slot wins) and drains the survivors into a 2-write-port register file, two
// per cycle, lowest slot first. Issue is back-pressured until the last drain
// cycle, which may accept the next bundle without a bubble.
//   clk, reset         clock, synchronous active-high reset
//   flush              discard pending writes at the edge (grants still driven this cycle)
//   bundle_valid/ready issue handshake; accept = valid & ready & !flush
//   slot_wen/addr/data per-slot write requests, slot i at [i*W +: W]
//   wr0_*/wr1_*        write-port enable/address/data
//   wr_sel             per-register data select, bit r=1 -> reg r takes port 1
//   busy               pending writes exist (DRAIN)
module regfile_wb_scheduler
  import regfile_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        bundle_valid,
  output logic                        bundle_ready,
  input  logic [NUM_SLOTS-1:0]        slot_wen,
  input  logic [NUM_SLOTS*ADDR_W-1:0] slot_addr,
  input  logic [NUM_SLOTS*DATA_W-1:0] slot_data,
  output logic                        wr0_en,
  output logic [ADDR_W-1:0]           wr0_addr,
  output logic [DATA_W-1:0]           wr0_data,
  output logic                        wr1_en,
  output logic [ADDR_W-1:0]           wr1_addr,
  output logic [DATA_W-1:0]           wr1_data,
  output logic [(1<<ADDR_W)-1:0]      wr_sel,
  output logic                        busy
);

  schedState_t           stateReg;
  logic [NUM_SLOTS-1:0]  pendMaskReg;
  logic [ADDR_W-1:0]     pendAddrReg [NUM_SLOTS];
  logic [DATA_W-1:0]     pendDataReg [NUM_SLOTS];

  logic [NUM_SLOTS-1:0]  filtMask;
  logic [NUM_SLOTS-1:0]  grant0;
  logic [NUM_SLOTS-1:0]  grant1;
  logic [NUM_SLOTS-1:0]  remaining;
  logic [MAX_SLOTS-1:0]  pendMaskExt;
  logic                  valid0;
  logic                  valid1;
  logic                  accept;

  // WAW filter: a slot survives only if no higher slot writes the same register.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : gFilter
    logic shadowed;
    always_comb begin
      shadowed = 1'b0;
      for (int j = gi + 1; j < NUM_SLOTS; j++) begin
        if (slot_wen[j] && (slot_addr[j*ADDR_W +: ADDR_W] == slot_addr[gi*ADDR_W +: ADDR_W]))
          shadowed = 1'b1;
      end
    end
    assign filtMask[gi] = slot_wen[gi] & ~shadowed;
  end

  lowest_two_picker #(.NUM_SLOTS(NUM_SLOTS)) picker (
    .mask   (pendMaskReg),
    .grant0 (grant0),
    .grant1 (grant1),
    .valid0 (valid0),
    .valid1 (valid1)
  );

  always_comb begin
    pendMaskExt                = '0;
    pendMaskExt[NUM_SLOTS-1:0] = pendMaskReg;
  end

  // Ready in the last drain cycle lets the next bundle follow with no gap.
  assign bundle_ready = (stateReg == IDLE) || (popcount(pendMaskExt) <= 4'(NUM_WR_PORTS));
  assign accept       = bundle_valid & bundle_ready & ~flush;
  assign remaining    = pendMaskReg & ~(grant0 | grant1);
  assign busy         = (stateReg == DRAIN);

  // Output mux is driven from registers only, so it is stable across the
  // negedge at which the register file samples.
  always_comb begin
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_addr = '0;
    wr1_addr = '0;
    wr0_data = '0;
    wr1_data = '0;
    wr_sel   = '0;
    if (stateReg == DRAIN) begin
      wr0_en = valid0;
      wr1_en = valid1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (grant0[i]) begin
          wr0_addr = wr0_addr | pendAddrReg[i];
          wr0_data = wr0_data | pendDataReg[i];
        end
        if (grant1[i]) begin
          wr1_addr = wr1_addr | pendAddrReg[i];
          wr1_data = wr1_data | pendDataReg[i];
        end
      end
      if (valid1) wr_sel[wr1_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= IDLE;
      pendMaskReg <= '0;
    end else if (flush) begin
      stateReg    <= IDLE;
      pendMaskReg <= '0;
    end else if (accept && (|filtMask)) begin
      // Accept only happens when the current drain finishes this cycle,
      // so overwriting the pending state loses nothing.
      stateReg    <= DRAIN;
      pendMaskReg <= filtMask;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pendAddrReg[i] <= slot_addr[i*ADDR_W +: ADDR_W];
        pendDataReg[i] <= slot_data[i*DATA_W +: DATA_W];
      end
    end else if (stateReg == DRAIN) begin
      pendMaskReg <= remaining;
      stateReg    <= (remaining == '0) ? IDLE : DRAIN;
    end
  end

endmodule
